run_merge_selector: RTL and testbench

Run-aware two-way block selector for the hardware merge sorter. It buffers E-record blocks from two input streams (A, B) in parametrised FIFOs, merges one sorted run of RUN_LEN blocks from each into a 2·RUN_LEN-block output run, and marks the run's final block. It feeds the E-record merge network, which it resets between runs via DOT_LAST. Unlike the free-running selector, it drains the surviving input when the other run is exhausted, so finite runs complete without sentinel records.

---
 rtl/run_merge_selector.sv | 235 +++++++++++++++++++++++
 tb/tb_run_merge_selector.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_merge_selector.sv
`default_nettype none
// ============================================================================
// Module   : run_merge_selector
// Purpose  : Run-aware two-way block selector for the hardware merge sorter.
//            Buffers E-record blocks from streams A and B in FWFT FIFOs,
//            merges one sorted run of RUN_LEN blocks from each side into a
//            2*RUN_LEN block output run, drains the surviving side once the
//            other is exhausted, and flags the final block with DOT_LAST.
// Options  : HMS_DESCEND_EN -- when defined, blocks are merged in descending
//            key order (record 0 of each block holds its largest key).
// Revision : 1.0 - initial release
// ============================================================================
module run_merge_selector #(
  parameter int E_LOG    = 2,
  parameter int DATW     = 64,
  parameter int KEYW     = 32,
  parameter int FIFO_LOG = 4,
  parameter int RUNW     = 16
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      IN_FULL,
  input  logic                      ENQ_A,
  input  logic                      ENQ_B,
  input  logic [(DATW<<E_LOG)-1:0]  DIN_A,
  input  logic [(DATW<<E_LOG)-1:0]  DIN_B,
  output logic                      FUL_A,
  output logic                      FUL_B,
  input  logic [RUNW-1:0]           RUN_LEN,
  output logic [(DATW<<E_LOG)-1:0]  DOT,
  output logic                      DOTEN,
  output logic                      DOT_LAST,
  output logic                      BUSY,
  output logic                      OVF
);

  localparam int                BW      = DATW << E_LOG;
  localparam int                DEPTH   = 1 << FIFO_LOG;
  localparam logic [FIFO_LOG:0] DEPTH_C = (FIFO_LOG+1)'(DEPTH);
  localparam logic [FIFO_LOG:0] FUL_THR = (FIFO_LOG+1)'(DEPTH - 2);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_MERGE   = 2'd1;
  localparam logic [1:0] S_DRAIN_A = 2'd2;
  localparam logic [1:0] S_DRAIN_B = 2'd3;

  // Per-stream FIFO storage and bookkeeping; index 0 is stream A, 1 is B.
  logic [BW-1:0]       mem    [2][DEPTH];
  logic [FIFO_LOG-1:0] wr_ptr [2];
  logic [FIFO_LOG-1:0] rd_ptr [2];
  logic [FIFO_LOG:0]   fcnt   [2];
  logic                enq    [2];
  logic                wr_ok  [2];
  logic                deq    [2];
  logic                empty  [2];
  logic [BW-1:0]       din    [2];
  logic [BW-1:0]       head   [2];

  logic          stall;
  logic [1:0]    state;
  logic          flip;
  logic [RUNW:0] run_len_q;
  logic [RUNW:0] cnt_a;
  logic [RUNW:0] cnt_b;
  logic [RUNW:0] cnt_a_inc;
  logic [RUNW:0] cnt_b_inc;

  logic [KEYW-1:0] key_a;
  logic [KEYW-1:0] key_b;
  logic            a_first;
  logic            b_first;
  logic            deq_a;
  logic            deq_b;
  logic            tie;
  logic            last;

  // FIFO port mapping, head (first-word-fall-through) and status decode.
  always_comb begin
    enq[0] = ENQ_A;
    enq[1] = ENQ_B;
    din[0] = DIN_A;
    din[1] = DIN_B;
    deq[0] = deq_a;
    deq[1] = deq_b;
    for (int s = 0; s < 2; s++) begin
      // A block arriving at a full FIFO is dropped even if a read happens.
      wr_ok[s] = enq[s] && (fcnt[s] != DEPTH_C);
      empty[s] = (fcnt[s] == '0);
      head[s]  = mem[s][rd_ptr[s]];
    end
  end

  assign FUL_A = (fcnt[0] >= FUL_THR);
  assign FUL_B = (fcnt[1] >= FUL_THR);

  // FIFO storage write; contents need no reset since occupancy is tracked.
  always_ff @(posedge CLK) begin
    for (int s = 0; s < 2; s++) begin
      if (wr_ok[s]) mem[s][wr_ptr[s]] <= din[s];
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int s = 0; s < 2; s++) begin
        wr_ptr[s] <= '0;
        rd_ptr[s] <= '0;
        fcnt[s]   <= '0;
      end
      OVF <= 1'b0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (wr_ok[s]) wr_ptr[s] <= wr_ptr[s] + 1'b1;
        if (deq[s])   rd_ptr[s] <= rd_ptr[s] + 1'b1;
        if (wr_ok[s] && !deq[s])      fcnt[s] <= fcnt[s] + 1'b1;
        else if (!wr_ok[s] && deq[s]) fcnt[s] <= fcnt[s] - 1'b1;
        if (enq[s] && !wr_ok[s]) OVF <= 1'b1;
      end
    end
  end

  // One-cycle registered copy of downstream back-pressure.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) stall <= 1'b0;
    else     stall <= IN_FULL;
  end

  assign key_a     = head[0][KEYW-1:0];
  assign key_b     = head[1][KEYW-1:0];
  assign cnt_a_inc = cnt_a + 1'b1;
  assign cnt_b_inc = cnt_b + 1'b1;

`ifdef HMS_DESCEND_EN
  assign a_first = (key_a > key_b);
  assign b_first = (key_b > key_a);
`else
  assign a_first = (key_a < key_b);
  assign b_first = (key_b < key_a);
`endif

  // Dequeue decision: compare heads while merging, plain drain otherwise.
  always_comb begin
    deq_a = 1'b0;
    deq_b = 1'b0;
    tie   = 1'b0;
    case (state)
      S_MERGE: begin
        if (!stall && !empty[0] && !empty[1]) begin
          if (a_first) begin
            deq_a = 1'b1;
          end else if (b_first) begin
            deq_b = 1'b1;
          end else begin
            // Equal keys alternate sources so neither stream is starved.
            tie   = 1'b1;
            deq_a = !flip;
            deq_b = flip;
          end
        end
      end
      S_DRAIN_A: deq_a = !stall && !empty[0];
      S_DRAIN_B: deq_b = !stall && !empty[1];
      default: begin
        deq_a = 1'b0;
        deq_b = 1'b0;
      end
    endcase
    // The run ends with the dequeue that exhausts the second side.
    last = (deq_a && (cnt_a_inc == run_len_q) && (cnt_b == run_len_q)) ||
           (deq_b && (cnt_b_inc == run_len_q) && (cnt_a == run_len_q));
  end

  // Run sequencing: per-side block counters, tie toggle and state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      run_len_q <= '0;
      cnt_a     <= '0;
      cnt_b     <= '0;
      flip      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt_a     <= '0;
          cnt_b     <= '0;
          flip      <= 1'b0;
          run_len_q <= '0;
          if (RUN_LEN != '0) begin
            run_len_q <= {1'b0, RUN_LEN};
            state     <= S_MERGE;
          end
        end
        S_MERGE: begin
          if (tie) flip <= !flip;
          if (deq_a) begin
            cnt_a <= cnt_a_inc;
            if (cnt_a_inc == run_len_q) state <= S_DRAIN_B;
          end
          if (deq_b) begin
            cnt_b <= cnt_b_inc;
            if (cnt_b_inc == run_len_q) state <= S_DRAIN_A;
          end
        end
        S_DRAIN_A: begin
          if (deq_a) cnt_a <= cnt_a_inc;
          if (last)  state <= S_IDLE;
        end
        S_DRAIN_B: begin
          if (deq_b) cnt_b <= cnt_b_inc;
          if (last)  state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign BUSY = (state != S_IDLE);

  // Registered output block, valid strobe and end-of-run marker.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DOT      <= '0;
      DOTEN    <= 1'b0;
      DOT_LAST <= 1'b0;
    end else begin
      DOTEN    <= deq_a || deq_b;
      DOT_LAST <= last;
      if (deq_a)      DOT <= head[0];
      else if (deq_b) DOT <= head[1];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_run_merge_selector.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_run_merge_selector
// Purpose  : Scoreboard bench for run_merge_selector. Expected output runs are
//            computed from the merge rules when stimulus is issued; a monitor
//            pops and compares on every DOTEN. Build with HMS_DESCEND_EN to
//            exercise the descending-order variant.
// Revision : 1.0 - initial release
// ============================================================================
module tb_run_merge_selector;

  localparam int E_LOG    = 2;
  localparam int DATW     = 64;
  localparam int KEYW     = 32;
  localparam int FIFO_LOG = 4;
  localparam int RUNW     = 16;
  localparam int BW       = DATW << E_LOG;

  typedef logic [BW-1:0] blk_t;
  typedef struct {
    blk_t data;
    logic last;
  } exp_t;

  logic            CLK = 1'b0;
  logic            RST;
  logic            IN_FULL;
  logic            ENQ_A, ENQ_B;
  blk_t            DIN_A, DIN_B;
  logic            FUL_A, FUL_B;
  logic [RUNW-1:0] RUN_LEN;
  blk_t            DOT;
  logic            DOTEN, DOT_LAST, BUSY, OVF;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   dot_seen    = 0;

  run_merge_selector #(
    .E_LOG(E_LOG), .DATW(DATW), .KEYW(KEYW), .FIFO_LOG(FIFO_LOG), .RUNW(RUNW)
  ) dut (
    .CLK(CLK), .RST(RST), .IN_FULL(IN_FULL),
    .ENQ_A(ENQ_A), .ENQ_B(ENQ_B), .DIN_A(DIN_A), .DIN_B(DIN_B),
    .FUL_A(FUL_A), .FUL_B(FUL_B), .RUN_LEN(RUN_LEN),
    .DOT(DOT), .DOTEN(DOTEN), .DOT_LAST(DOT_LAST), .BUSY(BUSY), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input blk_t act, input blk_t req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Ordering predicate of the merged output, straight from the sort order.
  function automatic bit goes_first(input int unsigned x, input int unsigned y);
`ifdef HMS_DESCEND_EN
    return x > y;
`else
    return x < y;
`endif
  endfunction

  // Table keys are written ascending; the descending build mirrors them.
  function automatic int unsigned map_key(input int unsigned k);
`ifdef HMS_DESCEND_EN
    return 1000 - k;
`else
    return k;
`endif
  endfunction

  function automatic blk_t mk_block(input int unsigned key);
    blk_t b;
    for (int i = 0; i < BW/32; i++) b[i*32 +: 32] = $urandom;
    b[KEYW-1:0] = KEYW'(key);
    return b;
  endfunction

  function automatic int unsigned key_of(input blk_t b);
    return int'(b[KEYW-1:0]);
  endfunction

  // Reference merge of two sorted runs with alternating tie-break.
  task automatic push_expected(input blk_t a[$], input blk_t b[$], input int n);
    int i = 0;
    int j = 0;
    bit flip = 0;
    for (int k = 0; k < 2*n; k++) begin
      exp_t e;
      bit take_a;
      if (i == n)      take_a = 0;
      else if (j == n) take_a = 1;
      else if (goes_first(key_of(a[i]), key_of(b[j]))) take_a = 1;
      else if (goes_first(key_of(b[j]), key_of(a[i]))) take_a = 0;
      else begin
        take_a = !flip;
        flip   = !flip;
      end
      e.data = take_a ? a[i] : b[j];
      if (take_a) i++; else j++;
      e.last = (k == 2*n-1);
      exp_q.push_back(e);
    end
  endtask

  // Enqueue both streams with random gaps and optional random back-pressure.
  task automatic feed(input blk_t a[$], input blk_t b[$], input int n, input bit rnd_stall);
    int ia = 0;
    int ib = 0;
    while (ia < n || ib < n) begin
      ENQ_A   = (ia < n) && ($urandom_range(0, 2) != 0);
      ENQ_B   = (ib < n) && ($urandom_range(0, 2) != 0);
      DIN_A   = (ia < n) ? a[ia] : '0;
      DIN_B   = (ib < n) ? b[ib] : '0;
      IN_FULL = rnd_stall && ($urandom_range(0, 3) == 0);
      @(posedge CLK); #1;
      if (ENQ_A) ia++;
      if (ENQ_B) ib++;
    end
    ENQ_A = 0;
    ENQ_B = 0;
  endtask

  task automatic start_run(input int n);
    RUN_LEN = RUNW'(n);
    @(posedge CLK); #1;
    RUN_LEN = '0;
    chk("busy_at_start", BUSY, 1);
  endtask

  task automatic wait_idle();
    int c = 0;
    IN_FULL = 0;
    while ((BUSY || exp_q.size() != 0) && c < 3000) begin
      @(posedge CLK); #1;
      c++;
    end
    chk("run_complete_pending", blk_t'(exp_q.size()), 0);
    chk("busy_after_run", BUSY, 0);
  endtask

  function automatic void mk_run(input int unsigned ka[$], output blk_t q[$]);
    q = {};
    foreach (ka[i]) q.push_back(mk_block(map_key(ka[i])));
  endfunction

  function automatic void rand_keys(input int n, output int unsigned ks[$]);
    int unsigned k = $urandom_range(0, 3);
    ks = {};
    for (int i = 0; i < n; i++) begin
      ks.push_back(k);
      k += $urandom_range(0, 2);
    end
  endfunction

  task automatic run_keys(input int unsigned ka[$], input int unsigned kb[$], input bit rnd_stall);
    blk_t a[$], b[$];
    mk_run(ka, a);
    mk_run(kb, b);
    push_expected(a, b, ka.size());
    start_run(ka.size());
    feed(a, b, ka.size(), rnd_stall);
    wait_idle();
  endtask

  // Monitor: every presented block must be the next one the model expects.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (DOTEN === 1'b1) begin
        dot_seen++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_dot: got DOTEN=1 data %h, required no output", DOT);
        end else begin
          e = exp_q.pop_front();
          chk("dot_data", DOT, e.data);
          chk("dot_last", DOT_LAST, e.last);
          if (e.last) chk("busy_with_last", BUSY, 0);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    blk_t a[$], b[$];
    int unsigned ka[$], kb[$];
    int k, c, base;

    RST = 1; IN_FULL = 0; ENQ_A = 0; ENQ_B = 0; DIN_A = '0; DIN_B = '0; RUN_LEN = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_dot", DOT, 0);
    chk("rst_doten", DOTEN, 0);
    chk("rst_dot_last", DOT_LAST, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_ovf", OVF, 0);
    chk("rst_ful_a", FUL_A, 0);
    chk("rst_ful_b", FUL_B, 0);
    RST = 0;
    @(posedge CLK); #1;

    // Directed cases: basic merge, drain, ties (twice to see flip reset).
    run_keys('{1, 5}, '{3, 7}, 0);
    run_keys('{1, 2, 3}, '{10, 11, 12}, 0);
    run_keys('{4, 4}, '{4, 4}, 0);
    run_keys('{4, 4}, '{4, 4}, 0);
`ifdef HMS_DESCEND_EN
    begin
      blk_t da[$], db[$];
      da = '{mk_block(9), mk_block(2)};
      db = '{mk_block(5), mk_block(1)};
      push_expected(da, db, 2);
      start_run(2);
      feed(da, db, 2, 0);
      wait_idle();
    end
`endif

    // Back-pressure held three cycles on a fully buffered run.
    rand_keys(6, ka); rand_keys(6, kb);
    mk_run(ka, a); mk_run(kb, b);
    push_expected(a, b, 6);
    feed(a, b, 6, 0);
    start_run(6);
    @(posedge CLK); #1;
    IN_FULL = 1;
    k = 0;
    repeat (3) begin
      @(posedge CLK); #1;
      if (DOTEN) k++;
    end
    IN_FULL = 0;
    chk("doten_during_stall_le1", (k <= 1), 1);
    wait_idle();

    // Randomized runs with random gaps and back-pressure.
    for (int r = 0; r < 12; r++) begin
      int n = $urandom_range(1, 8);
      rand_keys(n, ka);
      rand_keys(n, kb);
      run_keys(ka, kb, 1);
    end

    // Reset in the middle of a run discards everything.
    rand_keys(4, ka); rand_keys(4, kb);
    mk_run(ka, a); mk_run(kb, b);
    push_expected(a, b, 4);
    feed(a, b, 4, 0);
    base = dot_seen;
    start_run(4);
    c = 0;
    while (dot_seen < base + 2 && c < 100) begin
      @(negedge CLK);
      c++;
    end
    chk("two_dots_before_reset", (dot_seen >= base + 2), 1);
    #1 RST = 1;
    #1;
    chk("midrst_dot", DOT, 0);
    chk("midrst_doten", DOTEN, 0);
    chk("midrst_dot_last", DOT_LAST, 0);
    chk("midrst_busy", BUSY, 0);
    exp_q.delete();
    @(posedge CLK); #1;
    RST = 0;
    rand_keys(3, ka); rand_keys(3, kb);
    run_keys(ka, kb, 1);

    // FIFO limits: almost-full after 14, overflow on the 17th enqueue.
    rand_keys(17, ka); rand_keys(16, kb);
    mk_run(ka, a); mk_run(kb, b);
    for (int i = 0; i < 17; i++) begin
      ENQ_A = 1; DIN_A = a[i];
      @(posedge CLK); #1;
      ENQ_A = 0;
      if (i == 12) chk("ful_a_after_13", FUL_A, 0);
      if (i == 13) chk("ful_a_after_14", FUL_A, 1);
      if (i == 15) chk("ovf_after_16", OVF, 0);
      if (i == 16) chk("ovf_after_17", OVF, 1);
    end
    for (int i = 0; i < 16; i++) begin
      ENQ_B = 1; DIN_B = b[i];
      @(posedge CLK); #1;
      ENQ_B = 0;
    end
    chk("ful_b_full", FUL_B, 1);
    a.pop_back();
    push_expected(a, b, 16);
    start_run(16);
    wait_idle();
    chk("ovf_sticky", OVF, 1);
    chk("ful_a_drained", FUL_A, 0);
    repeat (4) @(posedge CLK);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
